// File: rtl/alu_cmd_issuer_if.sv
// Command/response stream bundle between the instruction front-end (master)
// and alu_cmd_issuer (slave).
interface alu_cmd_issuer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [2:0] rsp_flags;
    logic       rsp_illegal;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_illegal
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_illegal
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands in a FIFO, issues them one at a time to a combinational
// ALU and returns the captured result/flags as a backpressured response stream.
module alu_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_issuer_if.slave  cmd,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_op,
    input  logic [7:0]       alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic [CNT_W-1:0] fifo_count,
    output logic             busy
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    state_t           state;
    logic             pend_illegal;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign fifo_empty    = (fifo_count == '0);
    assign cmd.cmd_ready = !rst && (fifo_count != CNT_W'(DEPTH));
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    // A pop happens whenever the FSM is free to start the next command.
    assign pop           = !fifo_empty &&
                           ((state == IDLE) || ((state == HOLD) && cmd.rsp_ready));
    assign head          = mem[rd_ptr];
    assign busy          = (state != IDLE) || !fifo_empty;

    // NOTE: FIFO storage is deliberately not reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd.cmd_op, a: cmd.cmd_a, b: cmd.cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_count      <= '0;
            state           <= IDLE;
            pend_illegal    <= 1'b0;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_op          <= '0;
            cmd.rsp_valid   <= 1'b0;
            cmd.rsp_result  <= '0;
            cmd.rsp_flags   <= '0;
            cmd.rsp_illegal <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);

            // Opcodes 1110/1111 never reach the ALU; its inputs keep the last legal command.
            if (pop) begin
                pend_illegal <= (head.op[3:1] == 3'b111);
                if (head.op[3:1] != 3'b111) begin
                    alu_a  <= head.a;
                    alu_b  <= head.b;
                    alu_op <= head.op;
                end
            end

            case (state)
                IDLE: begin
                    if (pop) state <= ISSUE;
                end
                ISSUE: begin
                    cmd.rsp_result  <= pend_illegal ? 8'h00 : alu_result;
                    cmd.rsp_flags   <= pend_illegal ? 3'b000
                                                    : {alu_overflow, alu_carry, alu_zero};
                    cmd.rsp_illegal <= pend_illegal;
                    cmd.rsp_valid   <= 1'b1;
                    state           <= HOLD;
                end
                HOLD: begin
                    if (cmd.rsp_ready) begin
                        cmd.rsp_valid <= 1'b0;
                        state         <= pop ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios plus a randomized
// run, all scored against an in-order queue of expected responses.
module tb_alu_cmd_issuer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    typedef struct {
        logic [7:0] result;
        logic [2:0] flags;
        logic       illegal;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       alu_a, alu_b, alu_result;
    logic [3:0]       alu_op;
    logic             alu_zero, alu_carry, alu_overflow;
    logic [CNT_W-1:0] fifo_count;
    logic             busy;

    alu_cmd_issuer_if bus ();

    alu_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .fifo_count   (fifo_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: returns {overflow, carry, zero, result}.
    function automatic logic [10:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        case (op)
            4'h0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h1, 4'hD: begin
                r = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            default: begin
                r = a ^ b ^ {4'h0, op};
                c = 1'b0;
                v = 1'b0;
            end
        endcase
        return {v, c, (r == 8'h00), r};
    endfunction

    assign {alu_overflow, alu_carry, alu_zero, alu_result} = alu_fn(alu_op, alu_a, alu_b);

    function automatic rsp_t model_rsp(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
        rsp_t       r;
        logic [10:0] f;
        if (op >= 4'hE) begin
            r.result = 8'h00; r.flags = 3'b000; r.illegal = 1'b1;
        end else begin
            f = alu_fn(op, a, b);
            r.result = f[7:0]; r.flags = f[10:8]; r.illegal = 1'b0;
        end
        return r;
    endfunction

    rsp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_op = 4'h0;
    logic [7:0] last_a  = 8'h00;
    logic [7:0] last_b  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score any response handshake, log any accepted command, advance.
    task automatic tick();
        logic acc, hs, was_rst;
        rsp_t e;
        was_rst = rst;
        acc = bus.cmd_valid && bus.cmd_ready && !rst;
        hs  = bus.rsp_valid && bus.rsp_ready && !rst;
        if (hs) begin
            check("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_result",  bus.rsp_result,  e.result);
                check("rsp_flags",   bus.rsp_flags,   e.flags);
                check("rsp_illegal", bus.rsp_illegal, e.illegal);
            end
        end
        if (acc) begin
            exp_q.push_back(model_rsp(bus.cmd_op, bus.cmd_a, bus.cmd_b));
            if (bus.cmd_op < 4'hE) begin
                last_op = bus.cmd_op; last_a = bus.cmd_a; last_b = bus.cmd_b;
            end
        end
        @(posedge clk);
        #1;
        if (was_rst) exp_q.delete();
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic got = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
        for (int i = 0; i < 50; i++) begin
            got = bus.cmd_ready;
            tick();
            if (got) break;
        end
        check("send_accept", got, 1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 50; i++) begin
            if (bus.rsp_valid) break;
            tick();
        end
        check("wait_rsp", bus.rsp_valid, 1);
    endtask

    task automatic drain();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !bus.rsp_valid) break;
            tick();
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy, 0);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cop [6];
        logic [7:0] ca  [6];
        logic [7:0] cb  [6];
        int         k;
        int         sent;
        logic       got;

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 4'h0; bus.cmd_a = 8'h00; bus.cmd_b = 8'h00;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        bus.cmd_valid = 1'b1;
        check("rst_cmd_ready", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_rsp_valid",  bus.rsp_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_busy",       busy, 0);
        check("rst_alu",        {alu_a, alu_b, alu_op}, 0);
        check("rst_rsp_data",   {bus.rsp_result, bus.rsp_flags, bus.rsp_illegal}, 0);
        check("idle_cmd_ready", bus.cmd_ready, 1);

        // Latency: ADD 7F+01 accepted at edge N, popped at N+1, response after N+2.
        bus.cmd_valid = 1'b1; bus.cmd_op = 4'h0; bus.cmd_a = 8'h7F; bus.cmd_b = 8'h01;
        tick();
        bus.cmd_valid = 1'b0;
        check("lat_count_n",  fifo_count, 1);
        check("lat_valid_n",  bus.rsp_valid, 0);
        tick();
        check("lat_alu_n1",   {alu_a, alu_b, alu_op}, {8'h7F, 8'h01, 4'h0});
        check("lat_valid_n1", bus.rsp_valid, 0);
        check("lat_count_n1", fifo_count, 0);
        check("lat_busy_n1",  busy, 1);
        tick();
        check("lat_valid_n2", bus.rsp_valid, 1);
        check("add_result",   bus.rsp_result, 8'h80);
        check("add_flags",    bus.rsp_flags, 3'b100);
        check("add_illegal",  bus.rsp_illegal, 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("add_done_valid", bus.rsp_valid, 0);
        check("add_done_busy",  busy, 0);

        // SUB borrow, then CMP equality.
        send(4'h1, 8'h00, 8'h01);
        wait_rsp();
        check("sub_result", bus.rsp_result, 8'hFF);
        check("sub_flags",  bus.rsp_flags, 3'b010);
        drain();
        send(4'hD, 8'h05, 8'h05);
        wait_rsp();
        check("cmp_zero", bus.rsp_flags[0], 1);
        drain();

        // Capacity with response stalled: DEPTH+1 accepted out of 6 offered.
        for (int i = 0; i < 6; i++) begin
            cop[i] = 4'($urandom_range(0, 13));
            ca[i]  = 8'($urandom);
            cb[i]  = 8'($urandom);
        end
        k = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus.cmd_valid = (k < 6);
            if (k < 6) begin
                bus.cmd_op = cop[k]; bus.cmd_a = ca[k]; bus.cmd_b = cb[k];
            end
            got = bus.cmd_valid && bus.cmd_ready;
            tick();
            if (got) k++;
        end
        check("cap_accepted",   k, 5);
        check("cap_cmd_ready",  bus.cmd_ready, 0);
        check("cap_fifo_count", fifo_count, 4);
        check("cap_rsp_valid",  bus.rsp_valid, 1);
        bus.cmd_valid = 1'b0;

        // Response held stable under backpressure.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid",  bus.rsp_valid, 1);
            check("hold_result", bus.rsp_result, exp_q[0].result);
            check("hold_flags",  bus.rsp_flags, exp_q[0].flags);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("hs_valid_low", bus.rsp_valid, 0);
        check("hs_fifo_pop",  fifo_count, 3);
        tick();
        check("hs_next_valid", bus.rsp_valid, 1);
        drain();

        // Illegal opcode: zero response, ALU inputs untouched.
        send(4'hE, 8'hAA, 8'h55);
        wait_rsp();
        check("ill_flag",   bus.rsp_illegal, 1);
        check("ill_result", bus.rsp_result, 0);
        check("ill_flags",  bus.rsp_flags, 0);
        check("ill_alu",    {alu_a, alu_b, alu_op}, {last_a, last_b, last_op});
        drain();

        // Randomized traffic with random backpressure and illegal opcodes.
        sent = 0;
        bus.cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && (sent < 60 || exp_q.size() != 0); cyc++) begin
            if (!bus.cmd_valid && sent < 60 && $urandom_range(0, 3) != 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op = 4'($urandom_range(0, 15));
                bus.cmd_a  = 8'($urandom);
                bus.cmd_b  = 8'($urandom);
            end
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            got = bus.cmd_valid && bus.cmd_ready;
            tick();
            if (got) begin
                sent++;
                bus.cmd_valid = 1'b0;
            end
        end
        check("rand_sent", sent, 60);
        drain();

        // Reset while ISSUE with three commands queued.
        for (int i = 0; i < 4; i++) send(4'($urandom_range(0, 13)), 8'($urandom), 8'($urandom));
        check("pre_rst_count", fifo_count, 3);
        check("pre_rst_valid", bus.rsp_valid, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = 4'h0; bus.cmd_a = 8'h11; bus.cmd_b = 8'h22;
        bus.rsp_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        check("issue_valid", bus.rsp_valid, 0);
        check("issue_count", fifo_count, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_ready", bus.cmd_ready, 0);
        tick();
        check("mid_rst_valid", bus.rsp_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_alu",   {alu_a, alu_b, alu_op}, 0);
        rst = 1'b0;
        #1;
        send(4'h0, 8'h12, 8'h34);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
